// File: rtl/sequence_player_pkg.sv
// sequence_player_pkg: shared colour types, segment depth and timer sizing helper
package sequence_player_pkg;
  typedef logic [1:0] colour_t;
  typedef enum logic [1:0] {RED, GREEN, BLUE, YELLOW} colour_e;
  localparam int NUM_SEGMENTS = 33;
  localparam int IDX_W = 6;
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/sequence_player_if.sv
// sequence_player_if: game-side request and LED-side playback signals
interface sequence_player_if;
  import sequence_player_pkg::*;
  colour_t [NUM_SEGMENTS-1:0] segment;
  logic [IDX_W-1:0] seq_len;
  logic start;
  colour_t colour;
  logic led_on;
  logic [IDX_W-1:0] index;
  logic busy;
  logic done;
  modport master (output segment, seq_len, start, input colour, led_on, index, busy, done);
  modport slave (input segment, seq_len, start, output colour, led_on, index, busy, done);
endinterface

// File: rtl/sequence_player_phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags expiry
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else count <= load ? load_val : (count == '0) ? count : count - 1'b1;
  assign expired = (count == '0);
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays segment[0..len-1] as ON/OFF-timed colours, then pulses done
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int ON_CYCLES = 50,
  parameter int OFF_CYCLES = 25
) (
  input logic clk,
  input logic reset,
  sequence_player_if.slave bus
);
  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(NUM_SEGMENTS);
  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} play_state_t;
  play_state_t state, n_state;
  colour_t colour, n_colour;
  logic [IDX_W-1:0] index, n_index, len, n_len, len_in, next_index;
  logic led_on, n_led_on, busy, n_busy, done, n_done;
  logic load, expired;
  logic [TW-1:0] load_val;
  phase_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .expired(expired)
  );
  assign len_in = (bus.seq_len > MAX_LEN) ? MAX_LEN : bus.seq_len;
  assign next_index = index + 1'b1;
  always_comb begin
    n_state = state;
    n_colour = colour;
    n_index = index;
    n_len = len;
    n_led_on = led_on;
    n_busy = busy;
    n_done = 1'b0;
    load = 1'b0;
    load_val = ON_LOAD;
    case (state)
      IDLE: if (bus.start) begin
        n_len = len_in;
        n_index = '0;
        n_busy = 1'b1;
        n_state = (len_in == '0) ? FIN : ON;
        n_done = (len_in == '0);
        n_led_on = (len_in != '0);
        n_colour = (len_in != '0) ? bus.segment[0] : '0;
        load = (len_in != '0);
      end
      ON: if (expired) begin
        n_state = OFF;
        n_led_on = 1'b0;
        n_colour = '0;
        load = 1'b1;
        load_val = OFF_LOAD;
      end
      OFF: if (expired) begin
        if (index == len - 1'b1) begin
          n_state = FIN;
          n_done = 1'b1;
        end else begin
          n_state = ON;
          n_index = next_index;
          n_colour = bus.segment[next_index];
          n_led_on = 1'b1;
          load = 1'b1;
        end
      end
      default: begin
        n_state = IDLE;
        n_busy = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      colour <= '0;
      index <= '0;
      len <= '0;
      led_on <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= n_state;
      colour <= n_colour;
      index <= n_index;
      len <= n_len;
      led_on <= n_led_on;
      busy <= n_busy;
      done <= n_done;
    end
  assign bus.colour = colour;
  assign bus.led_on = led_on;
  assign bus.index = index;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: scoreboard bench checking ON-phase timing, colours, indices and done pulses
module tb_sequence_player;
  import sequence_player_pkg::*;
  localparam int ON_C = 4;
  localparam int OFF_C = 2;
  localparam int PER = ON_C + OFF_C;
  typedef struct {
    logic [1:0] c;
    int i;
    int t;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  ev_t q[$];
  int dq[$];
  ev_t e;
  logic [1:0] cur = 2'b00;
  logic prev_led = 1'b0;
  sequence_player_if bus ();
  sequence_player #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.led_on && !prev_led) begin
      if (q.size() == 0) check("led_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        cur = e.c;
        check("on_cycle", cyc, e.t);
        check("on_index", int'(bus.index), e.i);
      end
    end
    if (bus.led_on) check("colour_lit", int'(bus.colour), int'(cur));
    else check("colour_dark", int'(bus.colour), 0);
    if (bus.done) begin
      if (dq.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, dq.pop_front());
    end
    prev_led = bus.led_on;
  end
  task automatic play(input int n);
    int len;
    int s;
    @(negedge clk);
    s = cyc;
    len = (n > NUM_SEGMENTS) ? NUM_SEGMENTS : n;
    for (int k = 0; k < len; k++) q.push_back('{bus.segment[k], k, s + 1 + PER * k});
    dq.push_back(s + 1 + PER * len);
    bus.seq_len = 6'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy && q.size() == 0 && dq.size() == 0) return;
    end
    check("timeout", 1, 0);
  endtask
  task automatic set_abc();
    for (int k = 0; k < NUM_SEGMENTS; k++) bus.segment[k] = 2'b00;
    bus.segment[0] = 2'b01;
    bus.segment[1] = 2'b10;
    bus.segment[2] = 2'b11;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.seq_len = '0;
    set_abc();
    repeat (3) @(negedge clk);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_led_on", int'(bus.led_on), 0);
    check("rst_index", int'(bus.index), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    reset = 1'b0;
    play(3);
    check("busy_after_start", int'(bus.busy), 1);
    wait_done();
    check("busy_end_3", int'(bus.busy), 0);
    check("index_end_3", int'(bus.index), 2);
    play(0);
    check("len0_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("len0_busy_drop", int'(bus.busy), 0);
    wait_done();
    for (int k = 0; k < NUM_SEGMENTS; k++) bus.segment[k] = 2'b10;
    play(40);
    wait_done();
    check("index_end_40", int'(bus.index), NUM_SEGMENTS - 1);
    set_abc();
    play(3);
    repeat (6) @(negedge clk);
    check("restart_in_on", int'(bus.index), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    check("index_end_restart", int'(bus.index), 2);
    play(3);
    @(negedge clk);
    bus.segment[0] = 2'b11;
    wait_done();
    set_abc();
    play(3);
    repeat (10) @(negedge clk);
    check("pre_rst_index", int'(bus.index), 1);
    check("pre_rst_dark", int'(bus.led_on), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    dq.delete();
    check("mid_rst_colour", int'(bus.colour), 0);
    check("mid_rst_led_on", int'(bus.led_on), 0);
    check("mid_rst_index", int'(bus.index), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    play(3);
    wait_done();
    check("index_end_replay", int'(bus.index), 2);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
